// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared constants, FSM state type and round-robin search helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // First enabled index after ptr (wrapping); returns ptr itself if it is the only one.
  function automatic logic [1:0] next_en(input logic [1:0] ptr,
                                         input logic [NUM_CH-1:0] mask);
    logic [1:0] idx;
    next_en = ptr;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) next_en = idx;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1x4.sv
// ============================================================================
// Module   : demux_1x4
// Brief    : Combinational 1-to-4 demux; routes y to one of a..d by {S_1,S_0}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_1x4 (
  input  logic y,
  input  logic S_1,
  input  logic S_0,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  assign a = y & ~S_1 & ~S_0;
  assign b = y & ~S_1 &  S_0;
  assign c = y &  S_1 & ~S_0;
  assign d = y &  S_1 &  S_0;

endmodule

`default_nettype wire

// File: rtl/demux_rr_dispatcher.sv
// ============================================================================
// Module   : demux_rr_dispatcher
// Brief    : Round-robin burst dispatcher of one valid/ready stream onto four
//            channels through a single holding register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        chan_en,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [3:0]        out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy
);

  localparam logic [7:0] c_burst = 8'(BURST);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_hold_ch;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_data;

  logic             w_full;
  logic             w_fire;
  logic             w_accept;
  logic [1:0]       w_tgt;
  logic [7:0]       w_cnt_nxt;

  assign w_full   = (r_state == FULL);
  assign w_fire   = w_full & out_ready[r_hold_ch];
  // in_ready deliberately excludes in_valid so no valid->ready loop can form upstream.
  assign in_ready = ~rst & (|chan_en) & (~w_full | w_fire);
  assign w_accept = in_valid & in_ready;

  assign w_tgt     = chan_en[r_ptr] ? r_ptr : next_en(r_ptr, chan_en);
  assign w_cnt_nxt = (w_tgt != r_ptr) ? 8'd1 : (r_cnt + 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_ptr     <= 2'd0;
      r_hold_ch <= 2'd0;
      r_cnt     <= 8'd0;
      r_data    <= '0;
    end else begin
      case (r_state)
        EMPTY:   if (w_accept) r_state <= FULL;
        FULL:    if (w_fire && !w_accept) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase

      if (w_accept) begin
        r_data    <= in_data;
        r_hold_ch <= w_tgt;
        if (w_cnt_nxt == c_burst) begin
          r_ptr <= next_en(w_tgt, chan_en);
          r_cnt <= 8'd0;
        end else begin
          r_ptr <= w_tgt;
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign out_data = r_data;
  assign sel      = r_hold_ch;
  assign busy     = w_full;

  demux_1x4 u_demux (
    .y   (w_full),
    .S_1 (r_hold_ch[1]),
    .S_0 (r_hold_ch[0]),
    .a   (out_valid[0]),
    .b   (out_valid[1]),
    .c   (out_valid[2]),
    .d   (out_valid[3])
  );

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
// ============================================================================
// Module   : tb_demux_rr_dispatcher
// Brief    : Directed table-driven and sequence checks for demux_rr_dispatcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_rr_dispatcher;

  typedef struct {
    logic [3:0] en;
    logic       v;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       exp_ir;
    logic [3:0] exp_ov;
    logic [7:0] exp_od;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chan_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] out_ready;

  logic       ir2, busy2, ir1, busy1;
  logic [3:0] ov2, ov1;
  logic [7:0] od2, od1;
  logic [1:0] sel2, sel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.WIDTH(8), .BURST(2)) dut (
    .clk(clk), .rst(rst), .chan_en(chan_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ir2), .out_valid(ov2), .out_data(od2),
    .out_ready(out_ready), .sel(sel2), .busy(busy2)
  );

  demux_rr_dispatcher #(.WIDTH(8), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .chan_en(chan_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ir1), .out_valid(ov1), .out_data(od1),
    .out_ready(out_ready), .sel(sel1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    chan_en   = 4'b1111;
    out_ready = 4'b1111;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic exp_ir,
                              input logic [3:0] exp_ov, input logic [7:0] exp_od);
    vec_t r;
    r.en = 4'b1111; r.v = v; r.d = d; r.rdy = 4'b1111;
    r.exp_ir = exp_ir; r.exp_ov = exp_ov; r.exp_od = exp_od;
    return r;
  endfunction

  vec_t vt[10];

  initial begin
    vt[0] = mk(1'b1, 8'h10, 1'b1, 4'b0000, 8'h00);
    vt[1] = mk(1'b1, 8'h11, 1'b1, 4'b0001, 8'h10);
    vt[2] = mk(1'b1, 8'h12, 1'b1, 4'b0001, 8'h11);
    vt[3] = mk(1'b1, 8'h13, 1'b1, 4'b0010, 8'h12);
    vt[4] = mk(1'b1, 8'h14, 1'b1, 4'b0010, 8'h13);
    vt[5] = mk(1'b1, 8'h15, 1'b1, 4'b0100, 8'h14);
    vt[6] = mk(1'b1, 8'h16, 1'b1, 4'b0100, 8'h15);
    vt[7] = mk(1'b1, 8'h17, 1'b1, 4'b1000, 8'h16);
    vt[8] = mk(1'b0, 8'h00, 1'b1, 4'b1000, 8'h17);
    vt[9] = mk(1'b0, 8'h00, 1'b1, 4'b0000, 8'h17);

    // reset values, sampled while reset is held
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; chan_en = 4'b1111; out_ready = 4'b1111;
    #2;
    chk("rst_in_ready", 32'(ir2), 32'd0);
    chk("rst_out_valid", 32'(ov2), 32'd0);
    chk("rst_out_data", 32'(od2), 32'd0);
    chk("rst_sel", 32'(sel2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    do_reset();

    // full round-robin stream, BURST=2
    for (int i = 0; i < 10; i++) begin
      chan_en = vt[i].en; in_valid = vt[i].v; in_data = vt[i].d; out_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("rr_in_ready[%0d]", i), 32'(ir2), 32'(vt[i].exp_ir));
      chk($sformatf("rr_out_valid[%0d]", i), 32'(ov2), 32'(vt[i].exp_ov));
      chk($sformatf("rr_out_data[%0d]", i), 32'(od2), 32'(vt[i].exp_od));
      tick();
    end

    // sparse mask, BURST=1: channels 1,3,1,3
    do_reset();
    chan_en = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 4); in_data = 8'h20 + 8'(k);
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("sparse_ov[%0d]", k), 32'(ov1), 32'((k % 2 == 1) ? 4'b0010 : 4'b1000));
        chk($sformatf("sparse_od[%0d]", k), 32'(od1), 32'(8'h20 + 8'(k - 1)));
      end
      tick();
    end

    // stall on channel 0
    do_reset();
    out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_data = 8'hB6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_od", 32'(od2), 32'hA5);
      chk("stall_busy", 32'(busy2), 32'd1);
      chk("stall_in_ready", 32'(ir2), 32'd0);
      chk("stall_ov", 32'(ov2), 32'b0001);
      tick();
    end
    out_ready = 4'b1111;
    @(negedge clk);
    chk("unstall_in_ready", 32'(ir2), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("unstall_od", 32'(od2), 32'hB6);
    chk("unstall_ov", 32'(ov2), 32'b0001);
    tick();

    // disable channel 0 while its item is held
    do_reset();
    out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h30;
    tick();
    chan_en = 4'b1110; in_data = 8'h31;
    @(negedge clk);
    chk("dis_hold_ov", 32'(ov2), 32'b0001);
    chk("dis_hold_ir", 32'(ir2), 32'd0);
    tick();
    out_ready = 4'b0001;
    @(negedge clk);
    chk("dis_drain_ir", 32'(ir2), 32'd1);
    tick();
    out_ready = 4'b1111; in_data = 8'h32;
    @(negedge clk);
    chk("dis_next_ov", 32'(ov2), 32'b0010);
    chk("dis_next_od", 32'(od2), 32'h31);
    tick();
    in_data = 8'h33;
    @(negedge clk);
    chk("dis_restart_ov", 32'(ov2), 32'b0010);
    chk("dis_restart_od", 32'(od2), 32'h32);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("dis_advance_ov", 32'(ov2), 32'b0100);
    chk("dis_advance_od", 32'(od2), 32'h33);
    tick();

    // empty mask blocks acceptance
    do_reset();
    chan_en = 4'b0000; in_valid = 1'b1; in_data = 8'h40;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("nomask_ir", 32'(ir2), 32'd0);
      chk("nomask_busy", 32'(busy2), 32'd0);
      tick();
    end
    chan_en = 4'b0100;
    @(negedge clk);
    chk("mask2_ir", 32'(ir2), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mask2_ov", 32'(ov2), 32'b0100);
    chk("mask2_od", 32'(od2), 32'h40);
    tick();

    // asynchronous reset while holding on channel 3
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_data = 8'h60 + 8'(k);
      tick();
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    chk("pre_arst_sel", 32'(sel2), 32'd3);
    chk("pre_arst_ov", 32'(ov2), 32'b1000);
    chk("pre_arst_od", 32'(od2), 32'h66);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", 32'(ov2), 32'd0);
    chk("arst_busy", 32'(busy2), 32'd0);
    chk("arst_ir", 32'(ir2), 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h70; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_arst_ov", 32'(ov2), 32'b0001);
    chk("post_arst_sel", 32'(sel2), 32'd0);
    chk("post_arst_od", 32'(od2), 32'h70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
